// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end sharing one square-root core between
// N_REQ requesters, with a watchdog that answers with an error if the core stalls.
module sqrt_arbiter #(
  parameter int N_REQ       = 4,
  parameter int F_DW        = 7,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*(F_DW+1)-1:0] req_s_i,
  input  logic [N_REQ-1:0]          req_odd_i,
  input  logic [N_REQ-1:0]          req_inv_i,
  input  logic [N_REQ-1:0]          req_special_i,
  output logic [N_REQ-1:0]          resp_valid_o,
  output logic [2*(F_DW+1)-1:0]     resp_res_o,
  output logic                      resp_err_o,
  output logic                      core_doSqrt_o,
  output logic [F_DW:0]             core_s_o,
  output logic                      core_odd_o,
  output logic                      core_inv_o,
  output logic                      core_special_o,
  input  logic                      core_valid_i,
  input  logic [2*(F_DW+1)-1:0]     core_res_i,
  output logic                      busy_o
);
  localparam int SW = F_DW + 1;
  localparam int RW = 2 * SW;
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] s_q, s_d;
  logic          odd_q, odd_d, inv_q, inv_d, special_q, special_d;
  logic [RW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] cand, win_idx;
  logic          win_found;
  logic          handshake;

  // Round-robin scan starting one past the last winner.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign handshake = (state_q == IDLE) && win_found && rst;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    odd_d     = odd_q;
    inv_d     = inv_q;
    special_d = special_q;
    res_d     = res_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          gnt_d     = win_idx;
          rr_ptr_d  = win_idx;
          s_d       = req_s_i[int'(win_idx)*SW +: SW];
          odd_d     = req_odd_i[win_idx];
          inv_d     = req_inv_i[win_idx];
          special_d = req_special_i[win_idx];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completing core takes precedence over the watchdog.
        if (core_valid_i) begin
          res_d   = core_res_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_d == CW'(TIMEOUT_CYC - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Ready is qualified by rst so the grant vector is also quiet while held in reset.
    req_ready_o    = handshake ? (N_REQ'(1) << win_idx) : '0;
    resp_valid_o   = (state_q == RESP) ? (N_REQ'(1) << gnt_q) : '0;
    resp_res_o     = res_q;
    resp_err_o     = err_q;
    core_doSqrt_o  = (state_q == ISSUE);
    core_s_o       = s_q;
    core_odd_o     = odd_q;
    core_inv_o     = inv_q;
    core_special_o = special_q;
    busy_o         = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IW'(N_REQ - 1);
      gnt_q     <= '0;
      s_q       <= '0;
      odd_q     <= 1'b0;
      inv_q     <= 1'b0;
      special_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      odd_q     <= odd_d;
      inv_q     <= inv_d;
      special_q <= special_d;
      res_q     <= res_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
